// File: rtl/jtag_word_loader_if.sv
// Bus bundle for jtag_word_loader: host byte stream in, memory write port, response byte stream out.
// The slave modport is the loader's view; master is the environment driving it.
interface jtag_word_loader_if #(
  parameter int AddrWidth = 32
);
  logic                 in_canGet;
  logic [7:0]           in_getData;
  logic                 in_get;
  logic [AddrWidth-1:0] mem_address;
  logic [31:0]          mem_writedata;
  logic                 mem_write;
  logic                 mem_waitrequest;
  logic                 out_canGet;
  logic [7:0]           out_getData;
  logic                 out_get;

  modport slave (
    input  in_canGet, in_getData, mem_waitrequest, out_get,
    output in_get, mem_address, mem_writedata, mem_write, out_canGet, out_getData
  );

  modport master (
    output in_canGet, in_getData, mem_waitrequest, out_get,
    input  in_get, mem_address, mem_writedata, mem_write, out_canGet, out_getData
  );
endinterface

// File: rtl/jtag_word_loader.sv
// Parses header/address/count/data/checksum load frames from the host byte stream,
// writes little-endian words to memory and answers each frame with one ACK/NAK byte.
module jtag_word_loader #(
  parameter int          AddrWidth = 32,
  parameter logic [7:0]  Header    = 8'hA5,
  parameter logic [7:0]  AckByte   = 8'h06,
  parameter logic [7:0]  NakByte   = 8'h15
) (
  input  logic              clock,
  input  logic              reset,
  jtag_word_loader_if.slave bus,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_HDR, S_ADDR, S_CNT, S_DATA, S_WRITE, S_CSUM, S_RESP
  } state_t;

  state_t      state;
  logic [1:0]  byte_idx;
  logic [31:0] addr_q;
  logic [15:0] count_q;
  logic [31:0] word_q;
  logic [7:0]  sum_q;
  logic [7:0]  resp_q;
  logic        mem_write_q;
  logic        resp_valid_q;
  logic        intake_state;
  logic        accept;

  assign intake_state = (state == S_HDR) || (state == S_ADDR) || (state == S_CNT) ||
                        (state == S_DATA) || (state == S_CSUM);
  assign accept       = bus.in_canGet && intake_state;

  assign bus.in_get        = accept;
  // Address is assembled at full 32 bits; truncation drops the unused high bits
  // and makes the post-write increment wrap modulo 2^AddrWidth.
  assign bus.mem_address   = addr_q[AddrWidth-1:0];
  assign bus.mem_writedata = word_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.out_canGet    = resp_valid_q;
  assign bus.out_getData   = resp_q;
  assign busy              = (state != S_HDR);

  // NOTE: all state below updates with non-blocking assignments so every branch
  // sees the pre-edge values (e.g. sum_q compared before this cycle's update).
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_HDR;
      byte_idx     <= 2'd0;
      addr_q       <= '0;
      count_q      <= '0;
      word_q       <= '0;
      sum_q        <= '0;
      resp_q       <= '0;
      mem_write_q  <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      case (state)
        S_HDR: begin
          if (accept && bus.in_getData == Header) begin
            addr_q   <= '0;
            count_q  <= '0;
            sum_q    <= '0;
            byte_idx <= 2'd0;
            state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (accept) begin
            addr_q[8*byte_idx +: 8] <= bus.in_getData;
            byte_idx                <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) state <= S_CNT;
          end
        end
        S_CNT: begin
          if (accept) begin
            if (byte_idx == 2'd0) begin
              count_q[7:0] <= bus.in_getData;
              byte_idx     <= 2'd1;
            end else begin
              count_q[15:8] <= bus.in_getData;
              byte_idx      <= 2'd0;
              state <= ({bus.in_getData, count_q[7:0]} != 16'd0) ? S_DATA : S_CSUM;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            word_q[8*byte_idx +: 8] <= bus.in_getData;
            sum_q                   <= sum_q + bus.in_getData;
            byte_idx                <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_write_q <= 1'b1;
              state       <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (!bus.mem_waitrequest) begin
            mem_write_q <= 1'b0;
            addr_q      <= addr_q + 32'd1;
            count_q     <= count_q - 16'd1;
            byte_idx    <= 2'd0;
            state       <= (count_q == 16'd1) ? S_CSUM : S_DATA;
          end
        end
        S_CSUM: begin
          if (accept) begin
            resp_q       <= (bus.in_getData == sum_q) ? AckByte : NakByte;
            resp_valid_q <= 1'b1;
            byte_idx     <= 2'd0;
            state        <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.out_get) begin
            resp_valid_q <= 1'b0;
            byte_idx     <= 2'd0;
            state        <= S_HDR;
          end
        end
        default: state <= S_HDR;
      endcase
    end
  end

endmodule
